// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows the shared 32-bit datapath ALU.
// Produces the low 32 bits of a*b, one ALU operation per granted cycle.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_c,
  input  logic        alu_zero
);

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;

  typedef enum logic [1:0] {StIdle, StAdd, StShl, StShr} state_e;

  state_e      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [31:0] r_product;
  logic        r_busy;
  logic        r_done;

  // A cycle without alu_gnt freezes every register; ALU drive stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= a_in;
            r_mplier <= b_in;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_state  <= StAdd;
          end
        end
        StAdd: begin
          if (alu_gnt) begin
            if (r_mplier[0]) r_acc <= alu_c;
            r_state <= StShl;
          end
        end
        StShl: begin
          if (alu_gnt) begin
            r_mcand <= alu_c;
            r_state <= StShr;
          end
        end
        StShr: begin
          if (alu_gnt) begin
            r_mplier <= alu_c;
            if (alu_zero) begin
              r_product <= r_acc;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= StIdle;
            end else begin
              r_state <= StAdd;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_NOP;
    unique case (r_state)
      StIdle: ;
      StAdd: begin
        alu_a  = r_acc;
        alu_b  = r_mcand;
        alu_op = r_mplier[0] ? ALU_ADD : ALU_NOP;
      end
      StShl: begin
        alu_a  = 32'd1;
        alu_b  = r_mcand;
        alu_op = ALU_SLL;
      end
      StShr: begin
        alu_a  = 32'd1;
        alu_b  = r_mplier;
        alu_op = ALU_SRL;
      end
      default: ;
    endcase
  end

  assign busy    = r_busy;
  assign alu_req = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised self-checking bench for alu_mul_seq with an in-bench ALU and an
// operation-level reference model checked every cycle.
module tb_alu_mul_seq;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, alu_req, alu_zero;
  logic        alu_gnt = 1'b1;
  logic [31:0] product, alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;

  int n_chk = 0;
  int n_fail = 0;

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .alu_req(alu_req),
    .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Datapath ALU
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_c = alu_a + alu_b;
      ALU_SLL: alu_c = alu_b << alu_a;
      ALU_SRL: alu_c = alu_b >> alu_a;
      default: alu_c = alu_a;
    endcase
  end
  assign alu_zero = (alu_c == 32'd0);

  function automatic int kof(input logic [31:0] b);
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // Reference model: an operation takes 3k granted cycles, then product = a*b.
  logic        m_busy, m_done;
  logic [31:0] m_product, m_a, m_b;
  int          m_rem, m_k;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_product <= '0;
      m_a <= '0; m_b <= '0; m_rem <= 0; m_k <= 1;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1; m_a <= a_in; m_b <= b_in;
        m_k <= kof(b_in); m_rem <= 3 * kof(b_in);
      end
    end else if (alu_gnt) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_product <= m_a * m_b;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall_from,
                        input int stall_len, input int inj_at, output int cycles,
                        output int adds, output int stalls);
    start = 1'b1; a_in = a; b_in = b; alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; adds = 0; stalls = 0;
    for (int c = 1; c <= 400; c++) begin
      if (stall_from < 0) alu_gnt = ($urandom_range(0, 3) != 0);
      else alu_gnt = !(c >= stall_from && c < stall_from + stall_len);
      if (!alu_gnt) stalls++;
      if (alu_gnt && alu_op == ALU_ADD) adds++;
      start = (c == inj_at);
      if (c == inj_at) begin a_in = 32'd9; b_in = 32'd9; end
      @(posedge clk); #1;
      if (done) begin cycles = c; break; end
    end
    start = 1'b0; alu_gnt = 1'b1;
    chk("done_seen", {31'b0, (cycles > 0)}, 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, adds, st;
    logic [31:0] ra, rb;
    fork
      begin : compare
        logic [31:0] ea, eb, mask;
        logic [3:0]  eo;
        int step, it, ph;
        forever begin
          @(negedge clk);
          if (!rst) begin
            ea = '0; eb = '0; eo = ALU_NOP;
            if (m_busy) begin
              step = 3 * m_k - m_rem; it = step / 3; ph = step % 3;
              mask = (it == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - it));
              if (ph == 0) begin
                ea = m_a * (m_b & mask); eb = m_a << it;
                eo = m_b[it] ? ALU_ADD : ALU_NOP;
              end else if (ph == 1) begin
                ea = 32'd1; eb = m_a << it; eo = ALU_SLL;
              end else begin
                ea = 32'd1; eb = m_b >> it; eo = ALU_SRL;
              end
            end
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("alu_req", {31'b0, alu_req}, {31'b0, m_busy});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("product", product, m_product);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_op", {28'b0, alu_op}, {28'b0, eo});
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_op", {28'b0, alu_op}, {28'b0, ALU_NOP});
    @(posedge clk); #1;

    run_op(32'd5, 32'd0, 0, 0, 0, cyc, adds, st);
    chk("b0_cycles", cyc, 32'd3);
    chk("b0_product", product, 32'd0);
    chk("b0_adds", adds, 32'd0);

    run_op(32'd7, 32'd6, 0, 0, 0, cyc, adds, st);
    chk("7x6_cycles", cyc, 32'd9);
    chk("7x6_product", product, 32'd42);
    chk("7x6_adds", adds, 32'd2);

    run_op(32'hFFFF_FFFD, 32'd5, 0, 0, 0, cyc, adds, st);
    chk("neg3x5_cycles", cyc, 32'd9);
    chk("neg3x5_product", product, 32'hFFFF_FFF1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, cyc, adds, st);
    chk("msb_cycles", cyc, 32'd96);
    chk("msb_product", product, 32'h8000_0000);

    run_op(32'd7, 32'd6, 5, 4, 0, cyc, adds, st);
    chk("stall_cycles", cyc, 32'd13);
    chk("stall_product", product, 32'd42);

    run_op(32'd7, 32'd6, 0, 0, 4, cyc, adds, st);
    chk("ignore_start_cycles", cyc, 32'd9);
    chk("ignore_start_product", product, 32'd42);
    run_op(32'd9, 32'd9, 0, 0, 0, cyc, adds, st);
    chk("start_on_done_cycles", cyc, 32'd12);
    chk("start_on_done_product", product, 32'd81);

    start = 1'b1; a_in = 32'd7; b_in = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_req", {31'b0, alu_req}, 32'd0);
    chk("abort_product", product, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op(32'd3, 32'd4, 0, 0, 0, cyc, adds, st);
    chk("3x4_cycles", cyc, 32'd9);
    chk("3x4_product", product, 32'd12);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, -1, 0, (n % 3 == 0) ? int'($urandom_range(1, 6)) : 0, cyc, adds, st);
      chk("rand_product", product, ra * rb);
      chk("rand_cycles", cyc, 3 * kof(rb) + st);
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Shift-and-add multiply sequencer that time-shares the existing 32-bit ALU. It adds no multiplier hardware.
- Computes the low 32 bits of a*b, which is identical for signed and unsigned operands.
- Issues one ALU operation per cycle (ADD, SLL, SRL).
- Sits beside the CPU datapath. Requests the ALU with alu_req; the datapath operand/op mux hands it over via alu_gnt.

Parameters:
none (ALU width fixed at 32; ALUOp width fixed at 4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  request a multiply; sampled only in IDLE
a_in  in  32  multiplicand, latched on accepted start
b_in  in  32  multiplier, latched on accepted start
busy  out  1  high while in ADD/SHL/SHR
done  out  1  registered 1-cycle pulse; product valid
product  out  32  low 32 bits of a*b; held until next accepted start
alu_req  out  1  equals busy
alu_gnt  in  1  datapath grants ALU this cycle
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_op  out  4  ALUOp, encoded with the ctrl_encode_def macros
alu_c  in  32  ALU result
alu_zero  in  1  ALU Zero flag (alu_c == 0)

Behaviour:
- ALU contract:
  - ALU_ADD: C = A + B.
  - ALU_SLL: C = B << A.
  - ALU_SRL: C = B >> A.
  - ALU_NOP: C = A.
  - Combinational, so the result is usable in the same cycle.
- Internal registers: mcand, mplier, acc (32 each); state (2 bits).
- Reset (async, immediate): state=IDLE, mcand=mplier=acc=0, busy=0, done=0, product=0, alu_req=0.
- Outputs in IDLE: alu_a=0, alu_b=0, alu_op=ALU_NOP.
- IDLE:
  - start=1 → mcand<=a_in, mplier<=b_in, acc<=0, go to ADD.
  - done deasserts. product is unchanged until the final SHR of the new operation.
- ADD:
  - If mplier[0]=1: drive alu_a=acc, alu_b=mcand, op=ALU_ADD; acc<=alu_c.
  - Else: drive alu_a=acc, alu_b=mcand, op=ALU_NOP; acc unchanged.
  - Go to SHL.
- SHL: alu_a=1, alu_b=mcand, op=ALU_SLL; mcand<=alu_c; go to SHR.
- SHR:
  - alu_a=1, alu_b=mplier, op=ALU_SRL; mplier<=alu_c.
  - If alu_zero=1: product<=acc, done<=1, go to IDLE.
  - Else: go to ADD.
- Stall rule: in ADD/SHL/SHR, any cycle with alu_gnt=0 updates no register and keeps state. Outputs still hold that state's values.
- Iteration count: k = max(1, index of highest set bit of b + 1); range 1..32.
  - Exactly 3k granted cycles after the accept edge, done is high. Stall cycles add 1:1.
  - Termination relies on alu_zero only; mplier reaches 0 after at most 32 shifts.
- Overflow: the ADD result wraps mod 2^32; no flag.
- Start handling:
  - start while busy: ignored, no effect on the operation.
  - start in the cycle done=1 (state IDLE): accepted normally.
- done: high for exactly one cycle per completed operation.
- Reset mid-operation: aborts immediately. product returns to 0; no done pulse.

Test Plan:
- rst pulse, then a_in=5, b_in=0, start → done 3 cycles after accept edge; product=0; 1 ADD-state cycle issues ALU_NOP.
- a_in=7, b_in=6, gnt held 1 → done after 9 cycles; product=42; ALU_ADD issued exactly twice.
- a_in=0xFFFFFFFD (−3), b_in=5 → product=0xFFFFFFF1 (−15), 9 cycles. Then a_in=0xFFFFFFFF, b_in=0x80000000 → product=0x80000000, 96 cycles.
- a_in=7, b_in=6, alu_gnt=0 for 4 cycles during SHL of iteration 2 → done at cycle 13; product=42; alu_a/alu_b/alu_op stable while stalled.
- start with a_in=9, b_in=9 while busy on 7*6 → ignored; product=42. Start asserted during the done cycle → accepted, next product=81.
- rst asserted mid-operation (cycle 5 of 7*6) → busy, alu_req and product drop to 0 asynchronously; no done pulse. A subsequent 3*4 yields 12 after 9 cycles.
